// File: rtl/toilet_pkg.sv
// Shared types and constants for the water pump arbiter: FSM states, requester
// indices and default tick settings.
package toilet_pkg;

  typedef enum logic [1:0] {
    PUMP_IDLE  = 2'd0,
    PUMP_GRANT = 2'd1,
    PUMP_GAP   = 2'd2
  } pump_state_e;

  localparam int REQ_SPRAY = 0;
  localparam int REQ_DIS   = 1;
  localparam int REQ_FLUSH = 2;

  localparam int DEF_N_REQ           = 3;
  localparam int DEF_CNT_W           = 8;
  localparam int DEF_MAX_GRANT_TICKS = 200;
  localparam int DEF_GAP_TICKS       = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pump_arb_select.sv
// Combinational winner pick for the pump arbiter. PUMP_ARB_ROUND_ROBIN_EN selects
// round-robin from ptr; otherwise the lowest eligible index wins.
module pump_arb_select
  import toilet_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = idx_width(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] elig,
`ifdef PUMP_ARB_ROUND_ROBIN_EN
  input  logic [IDX_W-1:0] ptr,
`endif
  output logic [N_REQ-1:0] sel,
  output logic [IDX_W-1:0] sel_idx,
  output logic             any
);

  assign any = |elig;

  // Winner pick: walk from the far end so the highest-priority candidate is written last
  always_comb begin
    sel     = {N_REQ{1'b0}};
    sel_idx = {IDX_W{1'b0}};
`ifdef PUMP_ARB_ROUND_ROBIN_EN
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sel     = elig[(int'(ptr) + k) % N_REQ] ? (N_REQ'(1) << ((int'(ptr) + k) % N_REQ)) : sel;
      sel_idx = elig[(int'(ptr) + k) % N_REQ] ? IDX_W'((int'(ptr) + k) % N_REQ) : sel_idx;
    end
`else
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sel     = elig[i] ? (N_REQ'(1) << i) : sel;
      sel_idx = elig[i] ? IDX_W'(i) : sel_idx;
    end
`endif
  end

endmodule

// File: rtl/water_pump_arbiter.sv
// Grants the shared pump to one requester at a time with max on-time and a minimum
// off-gap. Define PUMP_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module water_pump_arbiter
  import toilet_pkg::*;
#(
  parameter int  N_REQ           = DEF_N_REQ,
  parameter int  CNT_W           = DEF_CNT_W,
  parameter int  MAX_GRANT_TICKS = DEF_MAX_GRANT_TICKS,
  parameter int  GAP_TICKS       = DEF_GAP_TICKS,
  localparam int IDX_W           = idx_width(N_REQ)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_id,
  output logic             pump_on,
  output logic             busy,
  output logic [N_REQ-1:0] timeout
);

  localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] GRANT_LAST = CNT_W'((MAX_GRANT_TICKS > 0) ? MAX_GRANT_TICKS - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  pump_state_e      state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [N_REQ-1:0] gnt_r, gnt_s, timeout_r, timeout_s, lockout_r, lockout_s;
  logic [N_REQ-1:0] elig_s, sel_s;
  logic [IDX_W-1:0] gnt_id_r, gnt_id_s, sel_idx_s;
  logic             pump_on_r, pump_on_s, busy_r, busy_s;
  logic             sel_any_s, owner_req_s, cnt_full_s;

  assign elig_s      = req & ~lockout_r;
  assign owner_req_s = |(req & gnt_r);
  assign cnt_full_s  = (cnt_r == CNT_SAT);

`ifdef PUMP_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_r, ptr_s;

  // Next search start is one past the new owner
  always_comb begin
    ptr_s = ptr_r;
    if (state_r == PUMP_IDLE && sel_any_s) begin
      ptr_s = (sel_idx_s == IDX_W'(N_REQ - 1)) ? {IDX_W{1'b0}} : sel_idx_s + IDX_W'(1);
    end else begin
      ptr_s = ptr_r;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_r <= {IDX_W{1'b0}};
    else          ptr_r <= ptr_s;
  end

  pump_arb_select #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_select (
    .elig(elig_s), .ptr(ptr_r), .sel(sel_s), .sel_idx(sel_idx_s), .any(sel_any_s)
  );
`else
  pump_arb_select #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_select (
    .elig(elig_s), .sel(sel_s), .sel_idx(sel_idx_s), .any(sel_any_s)
  );
`endif

  // Next-state and next-output logic; all outputs are registered below
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    gnt_s     = gnt_r;
    gnt_id_s  = gnt_id_r;
    pump_on_s = pump_on_r;
    busy_s    = busy_r;
    timeout_s = {N_REQ{1'b0}};
    lockout_s = lockout_r & req;
    case (state_r)
      PUMP_IDLE: begin
        if (sel_any_s) begin
          state_s   = PUMP_GRANT;
          cnt_s     = {CNT_W{1'b0}};
          gnt_s     = sel_s;
          gnt_id_s  = sel_idx_s;
          pump_on_s = 1'b1;
          busy_s    = 1'b1;
        end else begin
          gnt_s     = {N_REQ{1'b0}};
          gnt_id_s  = {IDX_W{1'b0}};
          pump_on_s = 1'b0;
          busy_s    = 1'b0;
        end
      end
      PUMP_GRANT: begin
        // A release always beats a coincident timeout
        if (!owner_req_s) begin
          state_s   = PUMP_GAP;
          cnt_s     = {CNT_W{1'b0}};
          gnt_s     = {N_REQ{1'b0}};
          gnt_id_s  = {IDX_W{1'b0}};
          pump_on_s = 1'b0;
        end else if (ce && (MAX_GRANT_TICKS != 0) && (cnt_r == GRANT_LAST)) begin
          state_s   = PUMP_GAP;
          cnt_s     = {CNT_W{1'b0}};
          gnt_s     = {N_REQ{1'b0}};
          gnt_id_s  = {IDX_W{1'b0}};
          pump_on_s = 1'b0;
          timeout_s = gnt_r;
          lockout_s = (lockout_r & req) | gnt_r;
        end else if (ce && !cnt_full_s) begin
          cnt_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_s = cnt_r;
        end
      end
      PUMP_GAP: begin
        if ((GAP_TICKS == 0) || (ce && (cnt_r == GAP_LAST))) begin
          state_s = PUMP_IDLE;
          cnt_s   = {CNT_W{1'b0}};
          busy_s  = 1'b0;
        end else if (ce && !cnt_full_s) begin
          cnt_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s   = PUMP_IDLE;
        cnt_s     = {CNT_W{1'b0}};
        gnt_s     = {N_REQ{1'b0}};
        gnt_id_s  = {IDX_W{1'b0}};
        pump_on_s = 1'b0;
        busy_s    = 1'b0;
      end
    endcase
  end

  // State, counter, lockout and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= PUMP_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      gnt_r     <= {N_REQ{1'b0}};
      gnt_id_r  <= {IDX_W{1'b0}};
      pump_on_r <= 1'b0;
      busy_r    <= 1'b0;
      timeout_r <= {N_REQ{1'b0}};
      lockout_r <= {N_REQ{1'b0}};
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      gnt_r     <= gnt_s;
      gnt_id_r  <= gnt_id_s;
      pump_on_r <= pump_on_s;
      busy_r    <= busy_s;
      timeout_r <= timeout_s;
      lockout_r <= lockout_s;
    end
  end

  assign gnt     = gnt_r;
  assign gnt_id  = gnt_id_r;
  assign pump_on = pump_on_r;
  assign busy    = busy_r;
  assign timeout = timeout_r;

endmodule

// File: tb/tb_water_pump_arbiter.sv
// Scoreboard bench for water_pump_arbiter: two instances (default timing, and
// no-timeout/no-gap) share stimulus and are compared against a behavioural model.
module tb_water_pump_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ce;
  logic [2:0] req;
  logic [2:0] gnt0, gnt1, to0, to1;
  logic [1:0] id0, id1;
  logic       pump0, pump1, busy0, busy1;

  water_pump_arbiter #(.N_REQ(3), .CNT_W(8), .MAX_GRANT_TICKS(200), .GAP_TICKS(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .req(req),
    .gnt(gnt0), .gnt_id(id0), .pump_on(pump0), .busy(busy0), .timeout(to0)
  );

  water_pump_arbiter #(.N_REQ(3), .CNT_W(8), .MAX_GRANT_TICKS(0), .GAP_TICKS(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .req(req),
    .gnt(gnt1), .gnt_id(id1), .pump_on(pump1), .busy(busy1), .timeout(to1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] gnt;
    logic [1:0] id;
    logic       pump;
    logic       busy;
    logic [2:0] to;
  } obs_t;

  obs_t exp_q0[$];
  obs_t exp_q1[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: phase 0 idle, 1 granted, 2 gap; ticks counts ce ticks in the phase
  int     mdl_max[2] = '{200, 0};
  int     mdl_gap[2] = '{4, 0};
  int     m_phase[2];
  int     m_owner[2];
  int     m_ticks[2];
  int     m_ptr[2];
  bit [2:0] m_lock[2];

  function automatic int pick(input bit [2:0] e, input int p);
    int w = -1;
    int s;
`ifdef PUMP_ARB_ROUND_ROBIN_EN
    s = p;
`else
    s = 0;
`endif
    for (int k = 0; k < 3; k++) begin
      if (w < 0 && e[(s + k) % 3]) w = (s + k) % 3;
    end
    return w;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0; m_owner[d] = 0; m_ticks[d] = 0; m_ptr[d] = 0; m_lock[d] = 3'b000;
    end
  endfunction

  function automatic obs_t model_step(input int d, input logic [2:0] r, input logic c);
    bit [2:0] elig;
    bit       to_hit = 1'b0;
    obs_t     o;
    elig = r & ~m_lock[d];
    if (m_phase[d] == 0) begin
      if (elig != 3'b000) begin
        m_owner[d] = pick(elig, m_ptr[d]);
        m_ptr[d]   = (m_owner[d] + 1) % 3;
        m_phase[d] = 1;
        m_ticks[d] = 0;
      end
    end else if (m_phase[d] == 1) begin
      if (!r[m_owner[d]]) begin
        m_phase[d] = 2; m_ticks[d] = 0;
      end else if (c) begin
        m_ticks[d]++;
        if (mdl_max[d] != 0 && m_ticks[d] == mdl_max[d]) begin
          m_phase[d] = 2; m_ticks[d] = 0; to_hit = 1'b1;
        end
      end
    end else begin
      if (mdl_gap[d] == 0) m_phase[d] = 0;
      else if (c) begin
        m_ticks[d]++;
        if (m_ticks[d] == mdl_gap[d]) m_phase[d] = 0;
      end
    end
    m_lock[d] = m_lock[d] & r;
    if (to_hit) m_lock[d][m_owner[d]] = 1'b1;
    o.gnt  = (m_phase[d] == 1) ? 3'(1 << m_owner[d]) : 3'b000;
    o.id   = (m_phase[d] == 1) ? 2'(m_owner[d]) : 2'd0;
    o.pump = (m_phase[d] == 1);
    o.busy = (m_phase[d] != 0);
    o.to   = to_hit ? 3'(1 << m_owner[d]) : 3'b000;
    return o;
  endfunction

  task automatic cyc(input logic [2:0] r, input logic c);
    @(negedge clk);
    req = r;
    ce  = c;
    exp_q0.push_back(model_step(0, r, c));
    exp_q1.push_back(model_step(1, r, c));
  endtask

  task automatic compare(input int d, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL sb%0d t=%0t got gnt=%b id=%0d pump=%b busy=%b to=%b want gnt=%b id=%0d pump=%b busy=%b to=%b",
               d, $time, act.gnt, act.id, act.pump, act.busy, act.to,
               exp.gnt, exp.id, exp.pump, exp.busy, exp.to);
    end
  endtask

  task automatic check_reset(input string name);
    checks++;
    if ({gnt0, id0, pump0, busy0, to0, gnt1, id1, pump1, busy1, to1} !== 20'd0) begin
      errors++;
      $display("FAIL %s got gnt0=%b pump0=%b busy0=%b gnt1=%b pump1=%b busy1=%b want all zero",
               name, gnt0, pump0, busy0, gnt1, pump1, busy1);
    end
  endtask

  // Monitor: one observation per clock, sampled just after the active edge
  always @(posedge clk) begin
    #1;
    if (exp_q0.size() > 0) compare(0, {gnt0, id0, pump0, busy0, to0}, exp_q0.pop_front());
    if (exp_q1.size() > 0) compare(1, {gnt1, id1, pump1, busy1, to1}, exp_q1.pop_front());
    checks++;
    if (pump0 !== (|gnt0) || pump1 !== (|gnt1) || !$onehot0(gnt0) || !$onehot0(gnt1)) begin
      errors++;
      $display("FAIL invariant t=%0t got gnt0=%b pump0=%b gnt1=%b pump1=%b want onehot0 gnt and pump==|gnt",
               $time, gnt0, pump0, gnt1, pump1);
    end
  end

  initial begin
    logic [2:0] rr;
    rr      = 3'b000;
    reset_n = 1'b0;
    req     = 3'b000;
    ce      = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #3;
    check_reset("reset_state");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) cyc(3'b000, 1'b1);

    // single requester, then release and gap
    cyc(3'b010, 1'b1);
    for (int i = 0; i < 8; i++) cyc(3'b010, 1'(i % 2));
    for (int i = 0; i < 12; i++) cyc(3'b000, 1'(i % 2));

    // simultaneous requests, owner not pre-empted, sequence 001,010,100
    repeat (6)  cyc(3'b111, 1'b1);
    repeat (10) cyc(3'b110, 1'b1);
    repeat (10) cyc(3'b100, 1'b1);
    repeat (8)  cyc(3'b000, 1'b1);

    // long hold: dut0 times out with lockout, dut1 (no timeout) keeps the grant
    repeat (320) cyc(3'b001, 1'b1);
    cyc(3'b000, 1'b1);
    repeat (8) cyc(3'b001, 1'b1);
    repeat (8) cyc(3'b000, 1'b1);

    // release coincident with the final tick: no timeout, no lockout
    repeat (200) cyc(3'b001, 1'b1);
    cyc(3'b000, 1'b1);
    repeat (6) cyc(3'b000, 1'b1);
    repeat (3) cyc(3'b001, 1'b1);

    // reset while granted, then a fresh grant one clock after release
    repeat (5) cyc(3'b100, 1'b1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset("reset_mid_grant");
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) cyc(3'b100, 1'b1);
    repeat (8) cyc(3'b000, 1'b1);

    // randomized sticky requests with random ce
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 7) == 0) rr[b] = ~rr[b];
      end
      cyc(rr, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL drain got q0=%0d q1=%0d want 0 0", exp_q0.size(), exp_q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
